// File: rtl/riscv_mc_core.sv
// Multi-cycle RV32I/RV32E core with req/ready instruction and data ports.
// Optional macro RISCV_MC_PERF_CNT_EN adds 64-bit cycle and retired-instruction counters.
module riscv_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready,
  input  logic [31:0] inst_i,
  output logic        data_req,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_o,
  input  logic        data_ready,
  input  logic [31:0] data_i,
  output logic        halted,
  output logic        trap
`ifdef RISCV_MC_PERF_CNT_EN
  ,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_cnt_o
`endif
);

  localparam int         RIDX_W = $clog2(NUM_REGS);
  localparam logic [5:0] NREGS  = 6'(NUM_REGS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      state_q, state_d;
  logic        start_q, trap_q;
  logic [31:0] pc_q, ir_q, rs1_q, rs2_q, imm_q, res_q, npc_q, addr_q;
  logic [31:0] regs_q [NUM_REGS];

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  logic        legal, uses_rd, uses_rs1, uses_rs2, is_sys, reg_bad, dec_bad;
  logic [31:0] imm;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    legal    = 1'b0;
    uses_rd  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    is_sys   = 1'b0;
    imm      = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        legal = 1'b1; uses_rd = 1'b1; imm = {ir_q[31:12], 12'b0};
      end
      OPC_JAL: begin
        legal = 1'b1; uses_rd = 1'b1;
        imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      end
      OPC_JALR: begin
        legal = (f3 == 3'd0); uses_rd = 1'b1; uses_rs1 = 1'b1;
        imm = {{20{ir_q[31]}}, ir_q[31:20]};
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'd2) && (f3 != 3'd3); uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      end
      OPC_LOAD: begin
        legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        uses_rd = 1'b1; uses_rs1 = 1'b1; imm = {{20{ir_q[31]}}, ir_q[31:20]};
      end
      OPC_STORE: begin
        legal = (f3 <= 3'd2); uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      end
      OPC_OPIMM: begin
        legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        uses_rd = 1'b1; uses_rs1 = 1'b1; imm = {{20{ir_q[31]}}, ir_q[31:20]};
      end
      OPC_OP: begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_SYSTEM: begin
        is_sys = (ir_q == 32'h0000_0073) || (ir_q == 32'h0010_0073);
        legal  = is_sys;
      end
      default: legal = 1'b0;
    endcase
  end

  assign reg_bad = (uses_rd  && {1'b0, rd}  >= NREGS) ||
                   (uses_rs1 && {1'b0, rs1} >= NREGS) ||
                   (uses_rs2 && {1'b0, rs2} >= NREGS);
  assign dec_bad = !legal || reg_bad;

  logic        is_load, is_store, taken, redirect, tgt_bad, mis_mem;
  logic [31:0] op_b, alu, exec_res, npc, mem_addr, pc4;
  logic [4:0]  shamt;

  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign op_b     = (opcode == OPC_OP) ? rs2_q : imm_q;
  assign shamt    = op_b[4:0];
  assign pc4      = pc_q + 32'd4;
  assign mem_addr = rs1_q + imm_q;

  always_comb begin
    case (f3)
      3'd0:    alu = (opcode == OPC_OP && f7[5]) ? rs1_q - op_b : rs1_q + op_b;
      3'd1:    alu = rs1_q << shamt;
      3'd2:    alu = {31'b0, $signed(rs1_q) < $signed(op_b)};
      3'd3:    alu = {31'b0, rs1_q < op_b};
      3'd4:    alu = rs1_q ^ op_b;
      3'd5:    alu = f7[5] ? 32'($signed(rs1_q) >>> shamt) : rs1_q >> shamt;
      3'd6:    alu = rs1_q | op_b;
      default: alu = rs1_q & op_b;
    endcase
    case (f3)
      3'd0:    taken = (rs1_q == rs2_q);
      3'd1:    taken = (rs1_q != rs2_q);
      3'd4:    taken = ($signed(rs1_q) <  $signed(rs2_q));
      3'd5:    taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'd6:    taken = (rs1_q <  rs2_q);
      3'd7:    taken = (rs1_q >= rs2_q);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    exec_res = alu;
    npc      = pc4;
    redirect = 1'b0;
    case (opcode)
      OPC_LUI:    exec_res = imm_q;
      OPC_AUIPC:  exec_res = pc_q + imm_q;
      OPC_JAL:    begin exec_res = pc4; npc = pc_q + imm_q; redirect = 1'b1; end
      OPC_JALR:   begin exec_res = pc4; npc = mem_addr & 32'hFFFF_FFFE; redirect = 1'b1; end
      OPC_BRANCH: if (taken) begin npc = pc_q + imm_q; redirect = 1'b1; end
      default:    ;
    endcase
  end

  assign tgt_bad = redirect && (npc[1:0] != 2'b00);
  assign mis_mem = (is_load || is_store) &&
                   ((f3[1:0] == 2'b01 && mem_addr[0]) ||
                    (f3[1:0] == 2'b10 && mem_addr[1:0] != 2'b00));

  logic [4:0]  lane_sh;
  logic [31:0] lane, load_val;
  assign lane_sh = {addr_q[1:0], 3'b000};
  assign lane    = data_i >> lane_sh;

  always_comb begin
    case (f3)
      3'd0:    load_val = {{24{lane[7]}}, lane[7:0]};
      3'd1:    load_val = {{16{lane[15]}}, lane[15:0]};
      3'd4:    load_val = {24'b0, lane[7:0]};
      3'd5:    load_val = {16'b0, lane[15:0]};
      default: load_val = lane;
    endcase
    case (f3[1:0])
      2'b00:   begin data_be_o = 4'b0001 << addr_q[1:0]; data_o = {24'b0, rs2_q[7:0]}  << lane_sh; end
      2'b01:   begin data_be_o = 4'b0011 << addr_q[1:0]; data_o = {16'b0, rs2_q[15:0]} << lane_sh; end
      default: begin data_be_o = 4'b1111;                data_o = rs2_q;                         end
    endcase
  end

  assign inst_req    = start_q && (state_q == S_FETCH);
  assign inst_addr_o = pc_q;
  assign data_req    = (state_q == S_MEM);
  assign data_we_o   = data_req && is_store;
  assign data_addr_o = {addr_q[31:2], 2'b00};
  assign halted      = (state_q == S_HALT);
  assign trap        = trap_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (inst_req && inst_ready) state_d = S_DECODE;
      S_DECODE: state_d = (dec_bad || is_sys) ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (mis_mem || tgt_bad) ? S_HALT :
                          (is_load || is_store) ? S_MEM : S_WB;
      S_MEM:    if (data_ready) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // NOTE: the register file is reset explicitly because cleared registers are architectural state here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
      trap_q  <= 1'b0;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      npc_q   <= '0;
      addr_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      start_q <= 1'b1;
      case (state_q)
        S_FETCH: if (inst_req && inst_ready) ir_q <= inst_i;
        S_DECODE: begin
          rs1_q <= regs_q[rs1[RIDX_W-1:0]];
          rs2_q <= regs_q[rs2[RIDX_W-1:0]];
          imm_q <= imm;
          if (dec_bad) trap_q <= 1'b1;
        end
        S_EXEC: begin
          res_q  <= exec_res;
          npc_q  <= npc;
          addr_q <= mem_addr;
          if (mis_mem || tgt_bad) trap_q <= 1'b1;
        end
        S_MEM: if (data_ready && is_load) res_q <= load_val;
        S_WB: begin
          if (uses_rd && rd != 5'd0) regs_q[rd[RIDX_W-1:0]] <= res_q;
          pc_q <= npc_q;
        end
        default: ;
      endcase
    end
  end

`ifdef RISCV_MC_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != S_HALT) cycle_cnt_q   <= cycle_cnt_q + 64'd1;
      if (state_q == S_WB)   instret_cnt_q <= instret_cnt_q + 64'd1;
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign instret_cnt_o = instret_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_mc_core.sv
// Directed bench for riscv_mc_core: split memories with programmable wait states.
module tb_riscv_mc_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_ready, data_req, data_we_o, data_ready, halted, trap;
  logic [31:0] inst_addr_o, inst_i, data_addr_o, data_o, data_i;
  logic [3:0]  data_be_o;

  logic        e_inst_req, e_data_req, e_data_we, e_halted, e_trap;
  logic [31:0] e_inst_addr, e_data_addr, e_data_o;
  logic [3:0]  e_data_be;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int inst_wait, data_wait, inst_cnt, data_cnt;
  int total = 0, bad = 0;

  typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] data; } dacc_t;
  logic [31:0] fetch_q [$];
  dacc_t       dacc_q  [$];
  int          dreq_cyc;
  logic        chk_stable = 1'b0, was_wait = 1'b0;
  logic [31:0] wait_addr;

  always #5 clk = ~clk;

  riscv_mc_core u_dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr_o(inst_addr_o), .inst_ready(inst_ready), .inst_i(inst_i),
    .data_req(data_req), .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_o(data_o), .data_ready(data_ready), .data_i(data_i),
    .halted(halted), .trap(trap)
  );

  // RV32E core with a non-zero reset PC, always fed ADDI x20,x0,1.
  riscv_mc_core #(.RESET_PC(32'h0000_0040), .NUM_REGS(16)) u_dut_e (
    .clk(clk), .rst(rst),
    .inst_req(e_inst_req), .inst_addr_o(e_inst_addr), .inst_ready(1'b1), .inst_i(32'h0010_0A13),
    .data_req(e_data_req), .data_we_o(e_data_we), .data_be_o(e_data_be), .data_addr_o(e_data_addr),
    .data_o(e_data_o), .data_ready(1'b1), .data_i(32'h0),
    .halted(e_halted), .trap(e_trap)
  );

  assign inst_ready = (inst_cnt >= inst_wait);
  assign data_ready = (data_cnt >= data_wait);
  assign inst_i     = imem[inst_addr_o[9:2]];
  assign data_i     = dmem[data_addr_o[9:2]];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_cnt <= 0;
      data_cnt <= 0;
    end else begin
      if (inst_req && inst_ready) inst_cnt <= 0;
      else if (inst_req)          inst_cnt <= inst_cnt + 1;
      if (data_req && data_ready) data_cnt <= 0;
      else if (data_req)          data_cnt <= data_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) dmem[i] <= '0;
    end else if (data_req && data_ready && data_we_o) begin
      for (int b = 0; b < 4; b++)
        if (data_be_o[b]) dmem[data_addr_o[9:2]][8*b +: 8] <= data_o[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      fetch_q.delete();
      dacc_q.delete();
      dreq_cyc = 0;
      was_wait = 1'b0;
    end else begin
      if (inst_req && inst_ready) fetch_q.push_back(inst_addr_o);
      if (data_req) begin
        dreq_cyc++;
        if (data_ready) dacc_q.push_back('{data_we_o, data_be_o, data_addr_o, data_o});
      end
      if (chk_stable && inst_req) begin
        if (was_wait) check("fetch_addr_stable", inst_addr_o, wait_addr);
        wait_addr = inst_addr_o;
        was_wait  = !inst_ready;
      end else begin
        was_wait = 1'b0;
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  localparam logic [6:0] OPIMM = 7'b0010011, LOAD = 7'b0000011, JALR = 7'b1100111;
  localparam logic [31:0] ECALL = 32'h0000_0073, EBREAK = 32'h0010_0073;

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = '0;
  endtask

  task automatic load_prog1();
    clear_imem();
    imem[0] = enc_i(12'd5,   5'd0, 3'd0, 5'd1, OPIMM);
    imem[1] = enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, OPIMM);
    imem[2] = {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
    imem[3] = ECALL;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_halt(input int max, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!halted && edges < max);
    if (!halted) check("halt_timeout", 32'(halted), 32'd1);
  endtask

  int          edges;
  logic [31:0] exp_pcs [13] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h08, 32'h0C,
                                32'h10, 32'h14, 32'h24, 32'h28, 32'h2C, 32'h30};

  initial begin
    rst       = 1'b0;
    inst_wait = 0;
    data_wait = 0;
    load_prog1();

    // Reset state and basic ALU program
    repeat (2) @(posedge clk);
    #1;
    check("rst_inst_req", 32'(inst_req), 32'd0);
    check("rst_data_req", 32'(data_req), 32'd0);
    check("rst_halted",   32'(halted),   32'd0);
    check("rst_trap",     32'(trap),     32'd0);
    check("rst_pc",       inst_addr_o,   32'h0);
    check("rst_pc_e",     e_inst_addr,   32'h40);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_inst_req", 32'(inst_req), 32'd0);
    run_halt(200, edges);
    check("t1_halt_cycle", 32'(edges), 32'd15);
    check("t1_x3",         u_dut.regs_q[3], 32'd2);
    check("t1_pc",         inst_addr_o, 32'h0C);
    check("t1_trap",       32'(trap), 32'd0);
    check("e_halted",      32'(e_halted), 32'd1);
    check("e_trap",        32'(e_trap), 32'd1);
    check("e_pc",          e_inst_addr, 32'h40);

    // Fetch wait states
    inst_wait  = 3;
    chk_stable = 1'b1;
    do_reset();
    run_halt(300, edges);
    check("t2_halt_cycle", 32'(edges), 32'd27);
    check("t2_x3",         u_dut.regs_q[3], 32'd2);
    check("t2_pc",         inst_addr_o, 32'h0C);
    chk_stable = 1'b0;
    inst_wait  = 0;

    // Word/byte stores, signed and unsigned byte loads
    clear_imem();
    imem[0] = enc_i(12'h100, 5'd0,  3'd0, 5'd10, OPIMM);
    imem[1] = enc_i(12'h123, 5'd0,  3'd0, 5'd1,  OPIMM);
    imem[2] = enc_i(12'h0AB, 5'd0,  3'd0, 5'd2,  OPIMM);
    imem[3] = enc_s(12'd0, 5'd1, 5'd10, 3'd2);
    imem[4] = enc_s(12'd3, 5'd2, 5'd10, 3'd0);
    imem[5] = enc_i(12'd3, 5'd10, 3'd0, 5'd3, LOAD);
    imem[6] = enc_i(12'd3, 5'd10, 3'd4, 5'd4, LOAD);
    imem[7] = enc_s(12'd4, 5'd3, 5'd10, 3'd2);
    imem[8] = enc_s(12'd8, 5'd4, 5'd10, 3'd2);
    imem[9] = EBREAK;
    data_wait = 1;
    do_reset();
    run_halt(400, edges);
    check("t3_nacc", 32'(dacc_q.size()), 32'd6);
    if (dacc_q.size() >= 2) begin
      check("t3_sw_we",   32'(dacc_q[0].we), 32'd1);
      check("t3_sw_be",   32'(dacc_q[0].be), 32'hF);
      check("t3_sw_addr", dacc_q[0].addr,    32'h100);
      check("t3_sw_data", dacc_q[0].data,    32'h123);
      check("t3_sb_be",   32'(dacc_q[1].be), 32'h8);
      check("t3_sb_addr", dacc_q[1].addr,    32'h100);
      check("t3_sb_data", dacc_q[1].data,    32'hAB00_0000);
    end
    check("t3_word", dmem[8'h40], 32'hAB00_0123);
    check("t3_lb",   dmem[8'h41], 32'hFFFF_FFAB);
    check("t3_lbu",  dmem[8'h42], 32'h0000_00AB);
    check("t3_trap", 32'(trap), 32'd0);
    check("t3_pc",   inst_addr_o, 32'h24);
    data_wait = 0;

    // Taken/not-taken BNE loop, JAL link
    clear_imem();
    imem[0]  = enc_i(12'd5,   5'd0, 3'd0, 5'd1, OPIMM);
    imem[1]  = enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, OPIMM);
    imem[2]  = enc_i(12'd1,   5'd3, 3'd0, 5'd3, OPIMM);
    imem[3]  = enc_i(12'd4,   5'd2, 3'd0, 5'd2, OPIMM);
    imem[4]  = enc_b(13'h1FF8, 5'd2, 5'd1, 3'd1);
    imem[5]  = enc_j(21'd16, 5'd5);
    imem[6]  = enc_i(12'd1, 5'd0, 3'd0, 5'd6, OPIMM);
    imem[9]  = enc_s(12'h140, 5'd5, 5'd0, 3'd2);
    imem[10] = enc_s(12'h144, 5'd3, 5'd0, 3'd2);
    imem[11] = enc_s(12'h148, 5'd6, 5'd0, 3'd2);
    imem[12] = ECALL;
    do_reset();
    run_halt(400, edges);
    check("t4_nfetch", 32'(fetch_q.size()), 32'd13);
    for (int i = 0; i < 13 && i < fetch_q.size(); i++)
      check($sformatf("t4_pc%0d", i), fetch_q[i], exp_pcs[i]);
    check("t4_x5_link", dmem[8'h50], 32'h18);
    check("t4_loops",   dmem[8'h51], 32'd2);
    check("t4_skipped", dmem[8'h52], 32'd0);
    check("t4_trap",    32'(trap), 32'd0);

    // Misaligned word load
    clear_imem();
    imem[0] = enc_i(12'h100, 5'd0,  3'd0, 5'd10, OPIMM);
    imem[1] = enc_i(12'd2,   5'd10, 3'd2, 5'd1,  LOAD);
    do_reset();
    run_halt(100, edges);
    check("t5_no_dreq", 32'(dreq_cyc), 32'd0);
    check("t5_halted",  32'(halted), 32'd1);
    check("t5_trap",    32'(trap), 32'd1);
    check("t5_pc",      inst_addr_o, 32'h04);

    // Misaligned JALR target
    clear_imem();
    imem[0] = enc_i(12'h102, 5'd0, 3'd0, 5'd1, OPIMM);
    imem[1] = enc_i(12'd0,   5'd1, 3'd0, 5'd0, JALR);
    do_reset();
    run_halt(100, edges);
    check("t5b_trap", 32'(trap), 32'd1);
    check("t5b_pc",   inst_addr_o, 32'h04);

    // Reset while a store waits for data_ready
    clear_imem();
    imem[0] = enc_i(12'd7, 5'd0, 3'd0, 5'd1, OPIMM);
    imem[1] = enc_s(12'h100, 5'd1, 5'd0, 3'd2);
    data_wait = 1000;
    do_reset();
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!data_req && edges < 50);
    check("t6_dreq_seen", 32'(data_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_dreq_drop", 32'(data_req), 32'd0);
    check("t6_ireq_drop", 32'(inst_req), 32'd0);
    repeat (2) @(posedge clk);
    data_wait = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_x1_clear", u_dut.regs_q[1], 32'd0);
    edges = 0;
    while (fetch_q.size() == 0 && edges < 20) begin
      @(negedge clk);
      #1;
      edges++;
    end
    check("t6_nfetch", 32'(fetch_q.size() > 0), 32'd1);
    if (fetch_q.size() > 0) check("t6_first_pc", fetch_q[0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_mc_core.md
Name: riscv_mc_core

Overview:
- Multi-cycle RV32I core: successor to the single-cycle top-level core.
- Same split instruction/data memory topology, but each fetch and each data access uses a req/ready handshake, so the core tolerates variable-latency memories.
- Adds a configurable register count (RV32I/RV32E), configurable reset PC, byte/half-word memory access, and a sticky halt/trap state.
- Register file, decode and ALU are internal.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NUM_REGS, 32, architectural register count; 32 (RV32I) or 16 (RV32E). Any rd/rs index >= NUM_REGS is illegal.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- inst_req  out  1  fetch request.
- inst_addr_o  out  32  fetch address (PC).
- inst_ready  in  1  fetch completes on a cycle where inst_req && inst_ready.
- inst_i  in  32  instruction word, sampled on fetch completion.
- data_req  out  1  data access request.
- data_we_o  out  1  1 = store, 0 = load; valid while data_req.
- data_be_o  out  4  byte enables, aligned to data_addr_o[1:0].
- data_addr_o  out  32  word-aligned address {addr[31:2],2'b00}.
- data_o  out  32  store data, lane-shifted to the byte enables.
- data_ready  in  1  access completes on data_req && data_ready.
- data_i  in  32  load data, sampled on completion.
- halted  out  1  core stopped (ECALL/EBREAK/trap); sticky until reset.
- trap  out  1  halt caused by an illegal instruction or a misaligned access.

Behaviour:
- Reset (rst=0, async): state=FETCH, PC=RESET_PC, all registers cleared to 0, inst_req=0 until the first clk after release, data_req=0, halted=0, trap=0.
- Reset mid-handshake: both requests drop immediately; any in-flight response is ignored.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: inst_req=1 while waiting. On completion, latch IR and go to DECODE.
- DECODE:
  - Read rs1/rs2 and generate the immediate (I/S/B/U/J).
  - Illegal opcode/funct, or a register index >= NUM_REGS: go to HALT with trap=1.
  - ECALL/EBREAK: go to HALT with trap=0.
  - Otherwise go to EXEC.
- EXEC:
  - ALU results: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND and their immediate forms, LUI, AUIPC. Shift amount is operand[4:0].
  - Branch compare: BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - Jumps: JAL/JALR; JALR target has bit0 cleared.
  - Loads/stores compute the address and go to MEM; all others go to WB.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0): HALT, trap=1.
  - Misaligned branch/jump target (target[1:0]!=0): HALT, trap=1.
- MEM:
  - data_req=1 with address, byte enables and lane-shifted store data held stable until completion.
  - LB/LH sign-extend and LBU/LHU zero-extend the selected lane.
  - Go to WB on completion.
- WB:
  - Write rd if the instruction writes; writes to x0 are discarded.
  - JAL/JALR write PC+4.
  - PC <= taken-branch/jump target, else PC+4. Go to FETCH.
- Cycle counts with zero-wait memory (ready tied high): ALU/branch/jump = 4 cycles, load/store = 5 cycles. Each wait cycle adds 1.
- HALT: no requests issued; PC frozen at the offending instruction; halted=1. Exit only via reset.
- Wrap-around: PC+4 wraps modulo 2^32; address arithmetic is 32-bit modulo.
- Register read-after-write is naturally resolved: a write in WB is visible to the next DECODE.

Optional Feature:
- Macro: RISCV_MC_PERF_CNT_EN.
- Defined:
  - Adds output ports cycle_cnt_o[63:0] and instret_cnt_o[63:0], both reset to 0.
  - cycle_cnt_o increments every clk while not halted.
  - instret_cnt_o increments on each WB exit.
  - Both counters wrap at 2^64.
- Undefined: the ports and counters do not exist; core behaviour is otherwise identical.

Test Plan:
- Reset, ready tied high, program "ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; ECALL" -> x3=2, halted=1 at cycle 16, PC=0x00C, trap=0.
- inst_ready low for 3 cycles on every fetch, same program -> identical results, halted at cycle 28; inst_addr_o stable while waiting.
- SW x1 to addr 0x100, then SB of 0xAB to 0x103, then LB and LBU from 0x103:
  - Store phases show data_be_o=4'b1111, then 4'b1000 with data_o=32'hAB00_0000.
  - Loads return 0xFFFF_FFAB (LB) and 0x0000_00AB (LBU).
- BNE taken (x1=5, x2=-3, offset -8) loops twice, then falls through -> PC sequence observed on inst_addr_o; JAL x5,+16 writes x5=PC+4.
- LW from 0x102 -> no data_req, halted=1, trap=1, PC held. Also: NUM_REGS=16 with ADDI x20,... -> trap=1.
- Assert rst during a data_req wait -> data_req falls asynchronously; after release, first fetch at RESET_PC and registers read 0.
